pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage CPU.
- Tracks in-flight destination registers in a 3-stage scoreboard (EX, MEM, WB) and stalls fetch/decode on read-after-write hazards, since there is no forwarding path.
- Sequences the multiplier: issues a one-cycle start and freezes EX until the multiplier reports completion or times out.
- Drives the PC/IF-ID hold, ID/EX bubble, ID/EX hold and EX/MEM bubble controls.

Parameters:
- RF_BYPASS, 0, 1 = register file writes through in the same cycle, so the WB scoreboard entry is excluded from hazard checks.
- MUL_TIMEOUT, 64, maximum cycles spent in MUL_WAIT before forced release (>=2).
- CNT_W, 16, width of the hazard performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  decode stage holds a real instruction
- id_rs  in  5  source register A of the decode instruction
- id_rt  in  5  source register B of the decode instruction
- id_uses_rt  in  1  id_rt is read (register operand or store data)
- id_rd  in  5  destination register of the decode instruction
- id_we  in  1  decode instruction writes the register file
- id_mul  in  1  decode instruction is a multiply
- mul_done  in  1  multiplier completion pulse, already synchronous to clk
- front_hold  out  1  hold PC and the IF/ID registers
- idex_bubble  out  1  load zero control into the ID/EX registers
- ex_hold  out  1  hold the ID/EX registers (multiplier operands stable)
- exmem_bubble  out  1  load zero control into the EX/MEM registers
- mul_start  out  1  multiplier start, one-cycle pulse
- mul_busy  out  1  FSM not in RUN
- mul_timeout  out  1  sticky flag: a multiply was force-released
- hazard_cnt  out  CNT_W  saturating count of RAW stall cycles

Behaviour:
- Reset (async):
  - FSM state = RUN; scoreboard entries invalid; wait counter = 0.
  - hazard_cnt = 0, mul_timeout = 0.
  - All control outputs 0.
- Scoreboard entry = {valid, rd}.
  - match(r) = r != 0 and r equals the rd of any valid entry among EX, MEM and WB (WB omitted when RF_BYPASS = 1).
- raw_hazard = id_valid && (match(id_rs) || (id_uses_rt && match(id_rt))).
- FSM states: RUN, MUL_ISSUE, MUL_WAIT. Outputs are combinational from state and inputs.
- RUN:
  - front_hold = idex_bubble = raw_hazard; ex_hold = 0; exmem_bubble = 0; mul_start = 0.
  - Shift scoreboard: WB <= MEM, MEM <= EX.
  - EX <= {id_valid && id_we && id_rd != 0 && !raw_hazard, id_rd}.
  - If id_valid && id_mul && !raw_hazard, go to MUL_ISSUE (the mul is now in EX).
  - hazard_cnt += 1 on every RUN cycle with raw_hazard, saturating at all-ones.
- MUL_ISSUE (exactly 1 cycle):
  - mul_start = 1, front_hold = 1, ex_hold = 1, exmem_bubble = 1, idex_bubble = 0.
  - Scoreboard: EX held, WB <= MEM, MEM <= invalid.
  - Clear the wait counter and go to MUL_WAIT. mul_done in this state is ignored.
- MUL_WAIT without release:
  - Same outputs as MUL_ISSUE except mul_start = 0.
  - Same scoreboard update as MUL_ISSUE; wait counter increments.
- Release cycle = MUL_WAIT with mul_done = 1, or wait counter == MUL_TIMEOUT-1:
  - Outputs: front_hold = 1, ex_hold = 0, idex_bubble = 1 (mul not re-executed), exmem_bubble = 0 (product captured).
  - Scoreboard: WB <= MEM, MEM <= EX, EX <= invalid. Next state RUN.
  - The held decode instruction is re-checked in RUN on the following cycle.
- Timeout release without mul_done sets mul_timeout; it stays set until rst.
- mul_done arriving simultaneously with the timeout counts as a normal completion (no flag).
- mul_busy = (state != RUN).
- rst asserted mid-multiply: immediate return to the reset state; no mul_start is reissued.

Test Plan:
- RF_BYPASS=0: issue rd=3 (we=1); next cycle id_rs=3 -> front_hold = idex_bubble = 1 for exactly 3 cycles, released on the 4th, hazard_cnt = 3. Repeat with RF_BYPASS=1 -> 2 stall cycles, hazard_cnt = 2.
- Issue rd=0 then id_rs=0, id_rt=0 -> no stall. Immediate op with id_uses_rt=0 and id_rt equal to an in-flight rd -> no stall, hazard_cnt unchanged.
- Issue mul rd=5 -> mul_start high exactly 1 cycle after issue; mul_done 6 cycles after mul_start -> front_hold high throughout, exmem_bubble high until the release cycle, RUN resumes. A dependent id_rs=5 then stalls 2 more cycles (MEM, WB).
- MUL_TIMEOUT=8, mul_done never asserted -> release after 8 MUL_WAIT cycles, mul_timeout = 1 and stays 1 through later instructions until rst.
- Assert rst during MUL_WAIT -> all outputs 0 asynchronously, mul_busy = 0. After release, a dependent instruction on the old rd does not stall (scoreboard cleared).
- Force 2^CNT_W+5 hazard cycles (CNT_W=4, 21 cycles) -> hazard_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: RAW-hazard stalls from a 3-deep
// destination scoreboard, plus multiplier issue/wait sequencing.
module pipe_hazard_ctrl #(
  parameter bit          RF_BYPASS   = 1'b0,
  parameter int unsigned MUL_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_mul,
  input  logic             mul_done,
  output logic             front_hold,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic             exmem_bubble,
  output logic             mul_start,
  output logic             mul_busy,
  output logic             mul_timeout,
  output logic [CNT_W-1:0] hazard_cnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = $clog2(MUL_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MUL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {RUN, MUL_ISSUE, MUL_WAIT} state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: '0};

  state_t            state;
  sb_entry_t         sb_ex, sb_mem, sb_wb;
  logic [WAIT_W-1:0] wait_cnt;

  logic match_rs, match_rt, raw_hazard, mul_release, mul_go;

  function automatic logic hit(input sb_entry_t e, input logic [REG_W-1:0] r);
    return e.valid && (e.rd == r);
  endfunction

  // Register 0 never creates a dependency; WB is invisible when the RF writes through.
  always_comb begin
    match_rs = (id_rs != '0) &&
               (hit(sb_ex, id_rs) || hit(sb_mem, id_rs) || (!RF_BYPASS && hit(sb_wb, id_rs)));
    match_rt = (id_rt != '0) &&
               (hit(sb_ex, id_rt) || hit(sb_mem, id_rt) || (!RF_BYPASS && hit(sb_wb, id_rt)));
    raw_hazard  = id_valid && (match_rs || (id_uses_rt && match_rt));
    mul_release = (state == MUL_WAIT) && (mul_done || (wait_cnt == WAIT_LAST));
    mul_go      = id_valid && id_mul && !raw_hazard;
  end

  // Pipeline control decode
  always_comb begin
    front_hold   = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    mul_start    = 1'b0;
    mul_busy     = (state != RUN);
    case (state)
      RUN: begin
        front_hold  = raw_hazard;
        idex_bubble = raw_hazard;
      end
      MUL_ISSUE: begin
        mul_start    = 1'b1;
        front_hold   = 1'b1;
        ex_hold      = 1'b1;
        exmem_bubble = 1'b1;
      end
      MUL_WAIT: begin
        front_hold = 1'b1;
        if (mul_release) begin
          idex_bubble = 1'b1;
        end else begin
          ex_hold      = 1'b1;
          exmem_bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer, scoreboard and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      sb_ex       <= SB_EMPTY;
      sb_mem      <= SB_EMPTY;
      sb_wb       <= SB_EMPTY;
      wait_cnt    <= '0;
      hazard_cnt  <= '0;
      mul_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          sb_wb       <= sb_mem;
          sb_mem      <= sb_ex;
          sb_ex.valid <= id_valid && id_we && (id_rd != '0) && !raw_hazard;
          sb_ex.rd    <= id_rd;
          if (raw_hazard && (hazard_cnt != CNT_MAX)) begin
            hazard_cnt <= hazard_cnt + CNT_W'(1);
          end
          if (mul_go) begin
            state <= MUL_ISSUE;
          end
        end
        MUL_ISSUE: begin
          sb_wb        <= sb_mem;
          sb_mem.valid <= 1'b0;
          wait_cnt     <= '0;
          state        <= MUL_WAIT;
        end
        MUL_WAIT: begin
          sb_wb <= sb_mem;
          if (mul_release) begin
            sb_mem      <= sb_ex;
            sb_ex.valid <= 1'b0;
            state       <= RUN;
            if (!mul_done) begin
              mul_timeout <= 1'b1;
            end
          end else begin
            sb_mem.valid <= 1'b0;
            wait_cnt     <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (WB checked / RF bypass)
// share stimulus and are compared cycle by cycle against an in-flight-list model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO    = 8;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_uses_rt = 1'b0, id_we = 1'b0, id_mul = 1'b0, mul_done = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;

  logic             front_hold [2];
  logic             idex_bubble [2];
  logic             ex_hold [2];
  logic             exmem_bubble [2];
  logic             mul_start [2];
  logic             mul_busy [2];
  logic             mul_timeout [2];
  logic [CNT_W-1:0] hazard_cnt [2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RF_BYPASS(1'b0), .MUL_TIMEOUT(TO), .CNT_W(CNT_W)) u_nobyp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_we(id_we), .id_mul(id_mul), .mul_done(mul_done),
    .front_hold(front_hold[0]), .idex_bubble(idex_bubble[0]), .ex_hold(ex_hold[0]),
    .exmem_bubble(exmem_bubble[0]), .mul_start(mul_start[0]), .mul_busy(mul_busy[0]),
    .mul_timeout(mul_timeout[0]), .hazard_cnt(hazard_cnt[0])
  );

  pipe_hazard_ctrl #(.RF_BYPASS(1'b1), .MUL_TIMEOUT(TO), .CNT_W(CNT_W)) u_byp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_we(id_we), .id_mul(id_mul), .mul_done(mul_done),
    .front_hold(front_hold[1]), .idex_bubble(idex_bubble[1]), .ex_hold(ex_hold[1]),
    .exmem_bubble(exmem_bubble[1]), .mul_start(mul_start[1]), .mul_busy(mul_busy[1]),
    .mul_timeout(mul_timeout[1]), .hazard_cnt(hazard_cnt[1])
  );

  // ctl = {front_hold, idex_bubble, ex_hold, exmem_bubble, mul_start, mul_busy, mul_timeout}
  typedef struct packed {
    logic [1:0][6:0]       ctl;
    logic [1:0][CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: destination registers still in flight (0 = nothing), youngest first,
  // and the age of the current multiply (-1 none, 0 start cycle, k = k-th wait cycle).
  int inflight [2][3];
  int mul_age [2];
  int hcnt [2];
  bit mto [2];

  function automatic bit pending(input int i, input int r);
    int depth;
    depth = (i == 1) ? 2 : 3;
    for (int s = 0; s < depth; s++)
      if (r != 0 && inflight[i][s] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic retire_one(input int i, input int newest);
    inflight[i][2] = inflight[i][1];
    inflight[i][1] = inflight[i][0];
    inflight[i][0] = newest;
  endtask

  task automatic step(input int i, output logic [6:0] ctl, output logic [CNT_W-1:0] cnt);
    bit raw, fh, ib, eh, eb, st, bz, cur_mto;
    {fh, ib, eh, eb, st, bz} = '0;
    if (rst) begin
      for (int s = 0; s < 3; s++) inflight[i][s] = 0;
      mul_age[i] = -1;
      hcnt[i]    = 0;
      mto[i]     = 1'b0;
      ctl        = '0;
      cnt        = '0;
      return;
    end
    cnt     = CNT_W'(hcnt[i]);
    cur_mto = mto[i];
    raw = id_valid && (pending(i, int'(id_rs)) || (id_uses_rt && pending(i, int'(id_rt))));
    if (mul_age[i] < 0) begin
      fh = raw;
      ib = raw;
      if (raw && hcnt[i] < CMAX) hcnt[i]++;
      retire_one(i, (id_valid && id_we && !raw) ? int'(id_rd) : 0);
      if (id_valid && id_mul && !raw) mul_age[i] = 0;
    end else begin
      // The multiply sits in EX; nothing new enters MEM until it is released.
      bz = 1'b1;
      fh = 1'b1;
      if (mul_age[i] > 0 && (mul_done || mul_age[i] == int'(TO))) begin
        ib = 1'b1;
        if (!mul_done) mto[i] = 1'b1;
        retire_one(i, 0);
        mul_age[i] = -1;
      end else begin
        st = (mul_age[i] == 0);
        eh = 1'b1;
        eb = 1'b1;
        inflight[i][2] = inflight[i][1];
        inflight[i][1] = 0;
        mul_age[i]++;
      end
    end
    ctl = {fh, ib, eh, eb, st, bz, cur_mto};
  endtask

  task automatic cyc(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic [4:0] rd, input logic we, input logic mul,
                     input logic done);
    exp_t             e;
    logic [6:0]       c;
    logic [CNT_W-1:0] k;
    @(negedge clk);
    rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    id_rd = rd; id_we = we; id_mul = mul; mul_done = done;
    for (int i = 0; i < 2; i++) begin
      step(i, c, k);
      e.ctl[i] = c;
      e.cnt[i] = k;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: combinational outputs are sampled mid-cycle, after the inputs settle.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          act = {front_hold[i], idex_bubble[i], ex_hold[i], exmem_bubble[i],
                 mul_start[i], mul_busy[i], mul_timeout[i]};
          checks++;
          if (act !== e.ctl[i]) begin
            errors++;
            $display("FAIL ctl inst%0d t=%0t got %b want %b", i, $time, act, e.ctl[i]);
          end
          checks++;
          if (hazard_cnt[i] !== e.cnt[i]) begin
            errors++;
            $display("FAIL hazard_cnt inst%0d t=%0t got %0d want %0d", i, $time,
                     hazard_cnt[i], e.cnt[i]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) mul_age[i] = -1;
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);

    // RAW on rd=3: 3 stalls without bypass, 2 with bypass
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // r0 never stalls; unused rt never stalls
    cyc(1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    repeat (3) idle();

    // Multiply rd=5, done 6 cycles after start, dependent rs=5 held in decode
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++)
      cyc(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, logic'(k == 7));

    // Timeout: mul_done never arrives; flag must stay set afterwards
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    repeat (14) cyc(1'b0, 1'b1, 5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    repeat (4) idle();

    // Reset mid-multiply, then the old rd must not stall
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    repeat (3) idle();
    cyc(1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) idle();

    // Hazard counter saturation
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
      repeat (4) cyc(1'b0, 1'b1, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(logic'($urandom_range(0, 249) == 0), logic'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 5) == 0));
    end

    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
